dw_conv_pre_ctrl: RTL

DW_CONV_PRE_CTRL -- requirements
Module: dw_conv_pre_ctrl

---
 rtl/dw_conv_pre_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dw_conv_pre_ctrl.sv
// Depthwise-conv preprocess controller: frame config, pixel position tracking,
// row-buffer length/reset control and 3x3 window-valid generation.
module dw_conv_pre_ctrl #(
   parameter int unsigned MAX_WIDTH  = 320,
   parameter int unsigned MAX_HEIGHT = 320,
   parameter int unsigned DEPTH      = $clog2(MAX_WIDTH - 2),
   parameter int unsigned CW         = $clog2(MAX_WIDTH + 1),
   parameter int unsigned RW         = $clog2(MAX_HEIGHT + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cfg_start,
   input  logic [CW-1:0]    cfg_width,
   input  logic [RW-1:0]    cfg_height,
   input  logic             valid_in,
   output logic [DEPTH-1:0] buff_len_ctrl,
   output logic             buff_len_rst,
   output logic             win_valid,
   output logic             busy,
   output logic             frame_done,
   output logic             cfg_err,
   output logic [CW-1:0]    col_cnt,
   output logic [RW-1:0]    row_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONFIG = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [CW-1:0]    width_q;
   logic [CW-1:0]    width_d;
   logic [RW-1:0]    height_q;
   logic [RW-1:0]    height_d;
   logic [CW-1:0]    col_d;
   logic [RW-1:0]    row_d;
   logic [DEPTH-1:0] len_d;
   logic             len_rst_d;
   logic             win_d;
   logic             busy_d;
   logic             done_d;
   logic             err_d;
   logic             cfg_ok;

   // Frame geometry must leave room for at least one full 3x3 window
   assign cfg_ok = (cfg_width  >= CW'(3)) && (cfg_width  <= CW'(MAX_WIDTH)) &&
                   (cfg_height >= RW'(3)) && (cfg_height <= RW'(MAX_HEIGHT));

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and next-output logic; outputs are registered below
   always_comb begin
      state_d   = state_q;
      width_d   = width_q;
      height_d  = height_q;
      col_d     = col_cnt;
      row_d     = row_cnt;
      len_d     = buff_len_ctrl;
      len_rst_d = 1'b0;
      win_d     = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               if (cfg_ok) begin
                  width_d   = cfg_width;
                  height_d  = cfg_height;
                  len_d     = DEPTH'(cfg_width - CW'(2));
                  len_rst_d = 1'b1;
                  col_d     = '0;
                  row_d     = '0;
                  state_d   = CONFIG;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         CONFIG: begin
            state_d = RUN;
         end
         RUN: begin
            if (valid_in) begin
               win_d = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
               if (col_cnt == width_q - CW'(1)) begin
                  col_d = '0;
                  row_d = row_cnt + RW'(1);
                  if (row_cnt == height_q - RW'(1)) begin
                     state_d = DONE;
                  end
               end else begin
                  col_d = col_cnt + CW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // Registered outputs and latched frame geometry
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         width_q       <= '0;
         height_q      <= '0;
         col_cnt       <= '0;
         row_cnt       <= '0;
         buff_len_ctrl <= '0;
         buff_len_rst  <= 1'b0;
         win_valid     <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         cfg_err       <= 1'b0;
      end else begin
         width_q       <= width_d;
         height_q      <= height_d;
         col_cnt       <= col_d;
         row_cnt       <= row_d;
         buff_len_ctrl <= len_d;
         buff_len_rst  <= len_rst_d;
         win_valid     <= win_d;
         busy          <= busy_d;
         frame_done    <= done_d;
         cfg_err       <= err_d;
      end
   end

endmodule
